// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - Opcode constants recognised by ex_mdu (8-bit canonical values;
//     the top casts them to its OPC_W).
//   - FSM state encoding used by ex_mdu.
package mdu_pkg;

  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start          load dividend/divisor and begin DATA_W iterations
//   abort          drop the current operation
//   dividend       unsigned dividend magnitude
//   divisor        unsigned divisor magnitude (non-zero; caller handles zero)
//   quotient       quotient after the current step (final when done=1)
//   remainder      remainder after the current step (final when done=1)
//   done           high during the last iteration cycle
module mdu_div_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic             run;
  logic [CNT_W-1:0] cnt;

  // quo starts as the dividend and fills with quotient bits from the LSB
  logic [DATA_W-1:0] quo_p0;
  logic [DATA_W-1:0] rem_p0;
  logic [DATA_W-1:0] dvs_p0;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;

  // A failed trial means shifted < divisor, so its top bit is zero and the
  // restored value fits back into DATA_W bits.
  always_comb begin
    shifted   = {rem_p0, quo_p0[DATA_W-1]};
    trial     = shifted - {1'b0, dvs_p0};
    remainder = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    quotient  = {quo_p0[DATA_W-2:0], ~trial[DATA_W]};
  end

  assign done = run & (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (abort) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      if (done) run <= 1'b0;
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      quo_p0 <= dividend;
      rem_p0 <= '0;
      dvs_p0 <= divisor;
    end else if (run) begin
      quo_p0 <= quotient;
      rem_p0 <= remainder;
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit with HI/LO registers.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start_valid    EX holds a valid instruction this cycle
//   i_aluop        opcode (mult/multu/div/divu/mfhi/mthi/mflo/mtlo)
//   i_rs_data      dividend / multiplicand / mthi-mtlo source
//   i_rt_data      divisor / multiplier
//   flush          abort the current operation, HI/LO untouched
//   stall_req      hold the pipeline while an operation is accepted/running
//   busy           FSM not idle
//   done           one-cycle pulse while freshly written HI/LO are visible
//   hi, lo         current HI/LO registers
//   rd_data        mfhi -> hi, mflo -> lo, else 0 (combinational)
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 8,
  parameter int FAST_MUL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  input  logic [OPC_W-1:0]  i_aluop,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic              flush,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
    return n ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_if2(input logic [2*DATA_W-1:0] v, input logic n);
    return n ? (~v + (2*DATA_W)'(1)) : v;
  endfunction

  mdu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic is_mult, is_multu, is_div, is_divu;
  logic is_mfhi, is_mthi, is_mflo, is_mtlo;
  logic is_mul_op, is_div_op, is_signed;
  logic start_mul, start_div, mt_ok;

  logic signed [DATA_W-1:0] rs_s, rt_s;
  logic                     neg_a, neg_b;
  logic [DATA_W-1:0]        mag_a, mag_b;

  logic [DATA_W-1:0]   mcand_p0;
  logic [2*DATA_W-1:0] prod_p0;
  logic                neg_q_p0, neg_r_p0, div_zero_p0;
  logic [DATA_W-1:0]   dvd_raw_p0;

  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod_step, prod_fast, prod_nxt, mul_res;
  logic                mul_last;

  logic [DATA_W-1:0] div_q, div_r, div_hi, div_lo;
  logic              div_done, commit_mul, commit_div;

  always_comb begin
    is_mult   = (i_aluop == OPC_W'(OP_MULT));
    is_multu  = (i_aluop == OPC_W'(OP_MULTU));
    is_div    = (i_aluop == OPC_W'(OP_DIV));
    is_divu   = (i_aluop == OPC_W'(OP_DIVU));
    is_mfhi   = (i_aluop == OPC_W'(OP_MFHI));
    is_mthi   = (i_aluop == OPC_W'(OP_MTHI));
    is_mflo   = (i_aluop == OPC_W'(OP_MFLO));
    is_mtlo   = (i_aluop == OPC_W'(OP_MTLO));
    is_mul_op = is_mult | is_multu;
    is_div_op = is_div | is_divu;
    is_signed = is_mult | is_div;
  end

  // flush wins over any new operation or HI/LO move in the same cycle
  assign start_mul = (state == ST_IDLE) & start_valid & is_mul_op & ~flush;
  assign start_div = (state == ST_IDLE) & start_valid & is_div_op & ~flush;
  assign mt_ok     = (state == ST_IDLE) & start_valid & ~flush;

  // Signed operations work on magnitudes; the sign is applied at commit.
  always_comb begin
    rs_s  = i_rs_data;
    rt_s  = i_rt_data;
    neg_a = is_signed & (rs_s < 0);
    neg_b = is_signed & (rt_s < 0);
    mag_a = neg_if(i_rs_data, neg_a);
    mag_b = neg_if(i_rt_data, neg_b);
  end

  // Shift-add step: prod holds {partial, remaining multiplier bits}
  always_comb begin
    mul_sum   = {1'b0, prod_p0[2*DATA_W-1:DATA_W]} +
                (prod_p0[0] ? {1'b0, mcand_p0} : '0);
    prod_step = {mul_sum, prod_p0[DATA_W-1:1]};
    prod_fast = {{DATA_W{1'b0}}, mcand_p0} * {{DATA_W{1'b0}}, prod_p0[DATA_W-1:0]};
    prod_nxt  = (FAST_MUL != 0) ? prod_fast : prod_step;
    mul_res   = neg_if2(prod_nxt, neg_q_p0);
    mul_last  = (FAST_MUL != 0) ? 1'b1 : (cnt == LAST);
  end

  mdu_div_iter #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start_div & (i_rt_data != '0)),
    .abort     (flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  // most-negative / -1 needs no special case: the magnitude quotient
  // 2^(DATA_W-1) negates back to the most-negative value, remainder 0.
  always_comb begin
    if (div_zero_p0) begin
      div_lo = '1;
      div_hi = dvd_raw_p0;
    end else begin
      div_lo = neg_if(div_q, neg_q_p0);
      div_hi = neg_if(div_r, neg_r_p0);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_mul)      state_nxt = ST_MUL;
        else if (start_div) state_nxt = ST_DIV;
      end
      ST_MUL:  if (mul_last) state_nxt = ST_DONE;
      ST_DIV:  if (div_zero_p0 || div_done) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // Results land on the edge into DONE so HI/LO are visible while done=1.
  assign commit_mul = (state == ST_MUL) & (state_nxt == ST_DONE);
  assign commit_div = (state == ST_DIV) & (state_nxt == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start_mul || start_div) cnt <= '0;
      else if (state == ST_MUL || state == ST_DIV) cnt <= cnt + CNT_W'(1);
    end
  end

  // ---- stage p0: operands captured at start, product iterated in MUL ----
  always_ff @(posedge clk) begin
    if (start_mul || start_div) begin
      mcand_p0    <= mag_a;
      prod_p0     <= {{DATA_W{1'b0}}, mag_b};
      neg_q_p0    <= neg_a ^ neg_b;
      neg_r_p0    <= neg_a;
      dvd_raw_p0  <= i_rs_data;
      div_zero_p0 <= (i_rt_data == '0);
    end else if (state == ST_MUL) begin
      prod_p0 <= prod_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (commit_mul) begin
      {hi, lo} <= mul_res;
    end else if (commit_div) begin
      hi <= div_hi;
      lo <= div_lo;
    end else if (mt_ok && is_mthi) begin
      hi <= i_rs_data;
    end else if (mt_ok && is_mtlo) begin
      lo <= i_rs_data;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign stall_req = ((state == ST_IDLE) & start_valid & (is_mul_op | is_div_op)) |
                     (state == ST_MUL) | (state == ST_DIV);

  always_comb begin
    rd_data = '0;
    if (is_mfhi)      rd_data = hi;
    else if (is_mflo) rd_data = lo;
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: a 32-bit iterative instance and a 16-bit
// FAST_MUL instance share clock and reset.
module tb_ex_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sv, fl;
  logic [7:0]  op;
  logic [31:0] rs, rt;
  logic        stall, busy, done;
  logic [31:0] hi, lo, rd;

  logic        sv2, fl2;
  logic [7:0]  op2;
  logic [15:0] rs2, rt2;
  logic        stall2, busy2, done2;
  logic [15:0] hi2, lo2, rd2;

  ex_mdu #(.DATA_W(32), .OPC_W(8), .FAST_MUL(0)) dut (
    .clk(clk), .rst(rst), .start_valid(sv), .i_aluop(op),
    .i_rs_data(rs), .i_rt_data(rt), .flush(fl),
    .stall_req(stall), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .rd_data(rd)
  );

  ex_mdu #(.DATA_W(16), .OPC_W(8), .FAST_MUL(1)) dut16 (
    .clk(clk), .rst(rst), .start_valid(sv2), .i_aluop(op2),
    .i_rs_data(rs2), .i_rt_data(rt2), .flush(fl2),
    .stall_req(stall2), .busy(busy2), .done(done2),
    .hi(hi2), .lo(lo2), .rd_data(rd2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Start one mul/div at a negedge, follow it to done, check latency,
  // stall cycles, results and that done lasts a single cycle.
  task automatic run_op(input bit s16, input logic [7:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input int elat, input string nm);
    int cyc, stalls;
    @(negedge clk);
    if (s16) begin sv2 = 1'b1; op2 = o; rs2 = a[15:0]; rt2 = b[15:0]; end
    else     begin sv  = 1'b1; op  = o; rs  = a;       rt  = b;       end
    #1;
    stalls = (s16 ? stall2 : stall) ? 1 : 0;
    @(negedge clk);
    sv = 1'b0; op = 8'h00; sv2 = 1'b0; op2 = 8'h00;
    cyc = 1;
    #1;
    while (!(s16 ? done2 : done) && cyc < 200) begin
      if (s16 ? stall2 : stall) stalls++;
      @(negedge clk);
      #1;
      cyc++;
    end
    chk({nm, ".latency"}, 64'(cyc), 64'(elat));
    chk({nm, ".stall_cycles"}, 64'(stalls), 64'(elat));
    chk({nm, ".stall_in_done"}, {63'd0, s16 ? stall2 : stall}, 64'd0);
    chk({nm, ".hi"}, s16 ? {48'd0, hi2} : {32'd0, hi}, {32'd0, ehi});
    chk({nm, ".lo"}, s16 ? {48'd0, lo2} : {32'd0, lo}, {32'd0, elo});
    @(negedge clk);
    #1;
    chk({nm, ".done_pulse"}, {63'd0, s16 ? done2 : done}, 64'd0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          lat;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];

  initial begin
    bit seen;

    tbl[0]  = '{8'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    tbl[1]  = '{8'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
    tbl[2]  = '{8'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    tbl[3]  = '{8'h18, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 33};
    tbl[4]  = '{8'h19, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 33};
    tbl[5]  = '{8'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    tbl[6]  = '{8'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    tbl[7]  = '{8'h1B, 32'd100,      32'd7,        32'd2,        32'd14,       33};
    tbl[8]  = '{8'h1B, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 2};
    tbl[9]  = '{8'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    tbl[10] = '{8'h1B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 33};
    tbl[11] = '{8'h1A, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 2};
    tbl[12] = '{8'h1B, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 33};
    tbl[13] = '{8'h1A, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 33};

    rst = 1'b0; sv = 1'b0; fl = 1'b0; op = 8'h00; rs = '0; rt = '0;
    sv2 = 1'b0; fl2 = 1'b0; op2 = 8'h00; rs2 = '0; rt2 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.hi", {32'd0, hi}, 64'd0);
    chk("reset.lo", {32'd0, lo}, 64'd0);
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.done", {63'd0, done}, 64'd0);
    chk("reset.stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++)
      run_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo,
             tbl[i].lat, $sformatf("v%0d", i));

    // flush during a mult: FSM idles next edge, HI/LO keep last result
    @(negedge clk);
    sv = 1'b1; op = 8'h18; rs = 32'd3; rt = 32'd4;
    @(negedge clk);
    sv = 1'b0; op = 8'h00;
    repeat (9) @(negedge clk);
    fl = 1'b1;
    @(negedge clk);
    fl = 1'b0;
    #1;
    chk("flush.busy", {63'd0, busy}, 64'd0);
    chk("flush.stall", {63'd0, stall}, 64'd0);
    chk("flush.hi", {32'd0, hi}, {32'd0, tbl[NV-1].ehi});
    chk("flush.lo", {32'd0, lo}, {32'd0, tbl[NV-1].elo});
    seen = 1'b0;
    repeat (40) begin @(negedge clk); #1; if (done) seen = 1'b1; end
    chk("flush.no_done", {63'd0, seen}, 64'd0);

    // flush in the same cycle as a start: nothing starts
    @(negedge clk);
    sv = 1'b1; op = 8'h1B; rs = 32'd9; rt = 32'd3; fl = 1'b1;
    @(negedge clk);
    sv = 1'b0; op = 8'h00; fl = 1'b0;
    #1;
    chk("flush_start.busy", {63'd0, busy}, 64'd0);
    chk("flush_start.lo", {32'd0, lo}, {32'd0, tbl[NV-1].elo});

    // mthi while busy is ignored
    @(negedge clk);
    sv = 1'b1; op = 8'h19; rs = 32'd2; rt = 32'd3;
    @(negedge clk);
    sv = 1'b0; op = 8'h00;
    repeat (3) @(negedge clk);
    sv = 1'b1; op = 8'h11; rs = 32'hDEADBEEF;
    @(negedge clk);
    sv = 1'b0; op = 8'h00;
    #1;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk("mthi_busy.done_seen", {63'd0, seen}, 64'd1);
    chk("mthi_busy.hi", {32'd0, hi}, 64'd0);
    chk("mthi_busy.lo", {32'd0, lo}, 64'd6);

    // mthi/mfhi and mtlo/mflo without any stall
    @(negedge clk);
    sv = 1'b1; op = 8'h11; rs = 32'h12345678;
    #1;
    chk("mthi.stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    op = 8'h10;
    #1;
    chk("mfhi.rd", {32'd0, rd}, 64'h12345678);
    chk("mfhi.stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    op = 8'h13; rs = 32'hCAFEF00D;
    #1;
    chk("mtlo.stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    op = 8'h12;
    #1;
    chk("mflo.rd", {32'd0, rd}, 64'hCAFEF00D);
    chk("mflo.done", {63'd0, done}, 64'd0);
    op = 8'h00;
    #1;
    chk("nop.rd", {32'd0, rd}, 64'd0);
    @(negedge clk);
    sv = 1'b0;

    // reset at cycle 5 of a divide
    @(negedge clk);
    sv = 1'b1; op = 8'h1B; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    sv = 1'b0; op = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_div.hi", {32'd0, hi}, 64'd0);
    chk("rst_div.lo", {32'd0, lo}, 64'd0);
    chk("rst_div.busy", {63'd0, busy}, 64'd0);
    chk("rst_div.done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); #1; if (done || busy) seen = 1'b1; end
    chk("rst_div.quiet", {63'd0, seen}, 64'd0);

    // 16-bit FAST_MUL instance
    run_op(1'b1, 8'h18, 32'h0000FFFD, 32'h00000005, 32'h0000FFFF, 32'h0000FFF1, 2, "w16_mult");
    run_op(1'b1, 8'h19, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFE, 32'h00000001, 2, "w16_multu");
    run_op(1'b1, 8'h1A, 32'h0000FFF9, 32'h00000002, 32'h0000FFFF, 32'h0000FFFD, 17, "w16_div");
    run_op(1'b1, 8'h1A, 32'h00008000, 32'h0000FFFF, 32'h00000000, 32'h00008000, 17, "w16_ovf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/HI/LO width (even, 8..64).
REQ-002 SHALL have parameter OPC_W, default 8, aluop width.
REQ-003 SHALL have parameter FAST_MUL, default 0; 1 = multiply completes in one compute cycle, 0 = iterative shift-add.
REQ-004 SHALL have the following ports: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start_valid  in  1  EX holds a valid instruction this cycle.
REQ-008 i_aluop  in  OPC_W  opcode from id_ex.
REQ-009 i_rs_data  in  DATA_W  dividend/multiplicand/mthi-mtlo source.
REQ-010 i_rt_data  in  DATA_W  divisor/multiplier.
REQ-011 flush  in  1  abort current operation.
REQ-012 stall_req  out  1  hold the pipeline.
REQ-013 busy  out  1  FSM not IDLE.
REQ-014 done  out  1  one-cycle pulse when HI/LO update from mul/div.
REQ-015 hi  out  DATA_W; lo  out  DATA_W; current HI/LO registers.
REQ-016 rd_data  out  DATA_W  mfhi -> hi, mflo -> lo, else 0 (combinational).

Function
REQ-017 Opcodes: mult 8'h18, multu 8'h19, div 8'h1A, divu 8'h1B, mfhi 8'h10, mthi 8'h11, mflo 8'h12, mtlo 8'h13; all others ignored.
REQ-018 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-019 IDLE: start_valid & mul op -> MUL; start_valid & div op -> DIV; operands latched on that edge.
REQ-020 MUL SHALL take DATA_W cycles (1 if FAST_MUL=1), then -> DONE.
REQ-021 DIV SHALL be radix-2 restoring, DATA_W cycles, then -> DONE; divisor 0 SHALL skip iteration and -> DONE next cycle.
REQ-022 DONE: write {hi,lo}, assert done, -> IDLE; always exactly one cycle.
REQ-023 Iteration counter width SHALL be $clog2(DATA_W)+1, reset to 0 on every start.
REQ-024 stall_req SHALL equal (IDLE & start_valid & mul/div op) | MUL | DIV; deasserted in DONE.
REQ-025 Signed ops: compute on magnitudes, fix sign at end; quotient negative iff signs differ, remainder takes dividend sign.
REQ-026 mult/multu: {hi,lo} = full 2*DATA_W product; div/divu: lo = quotient, hi = remainder.
REQ-027 Divide by zero: lo = all ones, hi = dividend, done still pulsed.
REQ-028 mthi/mtlo in IDLE with start_valid SHALL write i_rs_data next edge; no done pulse; ignored when busy.
REQ-029 flush SHALL return FSM to IDLE next edge from any state, HI/LO unchanged, no done; flush with start in IDLE: flush wins.
REQ-030 Overflow on most-negative / -1 signed divide: lo = most-negative, hi = 0.

Reset
REQ-031 rst low SHALL immediately force IDLE, hi=0, lo=0, counter=0, done=0, busy=0; stall_req follows REQ-024.
REQ-032 Reset mid-operation SHALL discard partial results with no done pulse.

Structure
REQ-033 Opcode constants and FSM state encoding SHALL live in shared package mdu_pkg.
REQ-034 Divider datapath SHALL be sub-module mdu_div_iter (start, magnitudes in, quotient/remainder out, done).

Verification
REQ-035 multu 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done 1 cycle, stall_req high 33 cycles.
REQ-036 div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 5/0 -> lo=0xFFFFFFFF, hi=0x00000005 two cycles after start.
REQ-037 mult started, flush at cycle 10 -> IDLE next edge, hi/lo keep prior values, no done.
REQ-038 rst low at cycle 5 of div -> hi=lo=0, busy=0 immediately, no done after release.
REQ-039 mthi 0x12345678 then mfhi -> rd_data=0x12345678 next cycle, stall_req never asserted.
REQ-040 DATA_W=16, FAST_MUL=1: mult -3 x 5 -> hi=0xFFFF, lo=0xFFF1 two cycles after start.
